// File: rtl/uart_mmio_ctrl_if.sv
// Bus bundle between the CPU load/store decode, the serial engines and uart_mmio_ctrl.
interface uart_mmio_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        irq;

    // CPU and serial engines side.
    modport master (
        output addr, wdata, we, re, tx_busy, rx_valid, rx_data,
        input  rdata, tx_start, tx_data, irq
    );

    // Controller side.
    modport slave (
        input  addr, wdata, we, re, tx_busy, rx_valid, rx_data,
        output rdata, tx_start, tx_data, irq
    );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: TX holding register + start/busy sequencer,
// RX capture register, CON status/control register and level interrupt.
module uart_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0018,
    parameter int unsigned START_WAIT = 3
) (
    input  logic            clk,
    input  logic            reset,
    uart_mmio_ctrl_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;

    localparam logic [DATA_W-1:0] TXD_ADDR  = BASE_ADDR;
    localparam logic [DATA_W-1:0] RXD_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [DATA_W-1:0] CON_ADDR  = BASE_ADDR + 32'd8;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(START_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_SEND      = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                tx_start_q, tx_start_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic [BYTE_W-1:0]   hold_byte_q, hold_byte_d;
    logic                hold_full_q, hold_full_d;
    logic [BYTE_W-1:0]   rx_byte_q, rx_byte_d;
    logic                rx_full_q, rx_full_d;
    logic                overrun_q, overrun_d;
    logic                tx_done_q, tx_done_d;
    logic                txie_q, txie_d;
    logic                rxie_q, rxie_d;
    logic                irq_q, irq_d;
    logic                hold_clr;
    logic                done_set;
    logic                tx_busy_flag;
    logic [DATA_W-1:0]   rdata_c;

    logic txd_wr, con_wr, rxd_rd;
    assign txd_wr = bus.we && (bus.addr == TXD_ADDR);
    assign con_wr = bus.we && (bus.addr == CON_ADDR);
    assign rxd_rd = bus.re && (bus.addr == RXD_ADDR);

    // Upper store-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata[DATA_W-1:BYTE_W];

    assign tx_busy_flag = hold_full_q || (state_q != S_IDLE);

    // TX sequencer: next state, start pulse and frame-complete event.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        hold_clr   = 1'b0;
        done_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hold_full_q && !bus.tx_busy) begin
                    state_d    = S_START;
                    tx_start_d = 1'b1;
                    tx_data_d  = hold_byte_q;
                end
            end
            S_START: begin
                hold_clr   = 1'b1;
                wait_cnt_d = '0;
                state_d    = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = S_SEND;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (!bus.tx_busy) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A byte refilled during the frame starts right as the engine goes idle.
        if (done_set && hold_full_q) begin
            state_d    = S_START;
            tx_start_d = 1'b1;
            tx_data_d  = hold_byte_q;
        end
    end

    // Holding/RX registers and CON flags; hardware set wins over software clear.
    always_comb begin
        hold_byte_d = hold_byte_q;
        hold_full_d = hold_full_q;
        rx_byte_d   = rx_byte_q;
        rx_full_d   = rx_full_q;
        overrun_d   = overrun_q;
        tx_done_d   = tx_done_q;
        txie_d      = txie_q;
        rxie_d      = rxie_q;
        if (con_wr) begin
            txie_d = bus.wdata[0];
            rxie_d = bus.wdata[1];
            if (bus.wdata[2]) tx_done_d = 1'b0;
            if (bus.wdata[5]) overrun_d = 1'b0;
        end
        if (done_set) tx_done_d = 1'b1;
        if (hold_clr) hold_full_d = 1'b0;
        if (txd_wr) begin
            if (hold_full_q) begin
                overrun_d = 1'b1;
            end else begin
                hold_byte_d = bus.wdata[BYTE_W-1:0];
                hold_full_d = 1'b1;
            end
        end
        if (bus.rx_valid) begin
            if (!rx_full_q || rxd_rd) begin
                rx_byte_d = bus.rx_data;
                rx_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rxd_rd) begin
            rx_full_d = 1'b0;
        end
        irq_d = (txie_q && tx_done_q) || (rxie_q && rx_full_q);
    end

    // Read mux, combinational from the address.
    always_comb begin
        rdata_c = '0;
        if (bus.addr == TXD_ADDR) begin
            rdata_c = {{(DATA_W-BYTE_W){1'b0}}, hold_byte_q};
        end else if (bus.addr == RXD_ADDR) begin
            rdata_c = {{(DATA_W-BYTE_W){1'b0}}, rx_byte_q};
        end else if (bus.addr == CON_ADDR) begin
            rdata_c = {{(DATA_W-6){1'b0}}, overrun_q, tx_busy_flag, rx_full_q,
                       tx_done_q, rxie_q, txie_q};
        end
    end

    // State and register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            hold_byte_q <= '0;
            hold_full_q <= 1'b0;
            rx_byte_q   <= '0;
            rx_full_q   <= 1'b0;
            overrun_q   <= 1'b0;
            tx_done_q   <= 1'b0;
            txie_q      <= 1'b0;
            rxie_q      <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            hold_byte_q <= hold_byte_d;
            hold_full_q <= hold_full_d;
            rx_byte_q   <= rx_byte_d;
            rx_full_q   <= rx_full_d;
            overrun_q   <= overrun_d;
            tx_done_q   <= tx_done_d;
            txie_q      <= txie_d;
            rxie_q      <= rxie_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Bench for uart_mmio_ctrl: directed register/FSM scenarios, then a random
// phase checked against a register-level model with a queue of TX bytes.
module tb_uart_mmio_ctrl;
    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;
    localparam int RAND_CYCLES  = 600;
    localparam int DRAIN_CYCLES = 80;

    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_mmio_ctrl_if bus ();

    uart_mmio_ctrl #(
        .BASE_ADDR  (32'h4000_0018),
        .START_WAIT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, observed unfinished run, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Look at the combinational read mux without a load strobe.
    task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        cyc();
        bus.we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.re   = 1'b1;
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
        cyc();
        bus.re   = 1'b0;
    endtask

    // Reference model state for the random phase.
    logic        m_rx_full, m_ov, m_rxie, m_irq, m_txd_known;
    logic [7:0]  m_rx_byte, m_txd;
    logic [7:0]  txq[$];
    int          eng_left, eng_guard;

    initial begin
        logic        started, tx_idle, rx_v, rxd_rd, new_irq, do_ops;
        logic [7:0]  rx_d, b;
        logic [31:0] w, exp_con;
        int unsigned op;

        reset        = 1'b1;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.we       = 1'b0;
        bus.re       = 1'b0;
        bus.tx_busy  = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;

        // Reset while the engine is mid-frame.
        repeat (5) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_tx_start", 32'(bus.tx_start), 32'h0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h0);
        chk("rst_irq", 32'(bus.irq), 32'h0);
        peek(CON, 32'h00, "rst_con");
        peek(RXD, 32'h00, "rst_rxd");

        // Byte written while the engine is still busy waits for tx_busy to fall.
        wr(TXD, 32'h77);
        repeat (4) begin
            chk("busy_hold_no_start", 32'(bus.tx_start), 32'h0);
            peek(CON, 32'h10, "busy_hold_con");
            cyc();
        end
        bus.tx_busy = 1'b0;
        cyc();
        chk("post_busy_start", 32'(bus.tx_start), 32'h1);
        chk("post_busy_data", 32'(bus.tx_data), 32'h77);

        // Engine never raises busy: give up after three cycles and flag done.
        repeat (3) cyc();
        chk("timeout_single_pulse", 32'(bus.tx_start), 32'h0);
        peek(CON, 32'h10, "timeout_still_waiting");
        cyc();
        peek(CON, 32'h04, "timeout_done");

        // Single frame with txie: exact start latency, done and irq timing.
        wr(CON, 32'h05);
        peek(CON, 32'h01, "con_txie");
        chk("irq_off_txie", 32'(bus.irq), 32'h0);
        wr(TXD, 32'h5A);
        chk("tx_n1_no_start", 32'(bus.tx_start), 32'h0);
        cyc();
        chk("tx_n2_start", 32'(bus.tx_start), 32'h1);
        chk("tx_n2_data", 32'(bus.tx_data), 32'h5A);
        bus.tx_busy = 1'b1;
        cyc();
        chk("tx_n3_no_start", 32'(bus.tx_start), 32'h0);
        repeat (10416) cyc();
        bus.tx_busy = 1'b0;
        cyc();
        peek(CON, 32'h05, "tx_done_set");
        chk("irq_lag", 32'(bus.irq), 32'h0);
        cyc();
        chk("irq_tx", 32'(bus.irq), 32'h1);
        wr(CON, 32'h05);
        chk("irq_clear_lag", 32'(bus.irq), 32'h1);
        cyc();
        chk("irq_cleared", 32'(bus.irq), 32'h0);

        // Back-to-back frames, a dropped third write, and set-wins on tx_done.
        wr(TXD, 32'h11);
        cyc();
        chk("b2b_start1", 32'(bus.tx_start), 32'h1);
        chk("b2b_data1", 32'(bus.tx_data), 32'h11);
        bus.tx_busy = 1'b1;
        repeat (3) cyc();
        wr(TXD, 32'h22);
        wr(TXD, 32'h33);
        peek(CON, 32'h31, "b2b_overrun_con");
        peek(TXD, 32'h22, "b2b_txd_kept");
        repeat (10) begin
            chk("b2b_no_early_start", 32'(bus.tx_start), 32'h0);
            cyc();
        end
        bus.tx_busy = 1'b0;
        bus.we      = 1'b1;
        bus.addr    = CON;
        bus.wdata   = 32'h25;
        cyc();
        bus.we = 1'b0;
        chk("b2b_start2", 32'(bus.tx_start), 32'h1);
        chk("b2b_data2", 32'(bus.tx_data), 32'h22);
        peek(CON, 32'h15, "done_set_wins");
        bus.tx_busy = 1'b1;
        repeat (8) cyc();
        bus.tx_busy = 1'b0;
        repeat (6) begin
            cyc();
            chk("b2b_no_third", 32'(bus.tx_start), 32'h0);
        end

        // RX capture, overrun on a second byte, and irq following rx_full.
        wr(CON, 32'h06);
        cyc();
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        cyc();
        bus.rx_valid = 1'b0;
        peek(CON, 32'h0A, "rx_full_con");
        chk("rx_irq_lag", 32'(bus.irq), 32'h0);
        cyc();
        chk("rx_irq", 32'(bus.irq), 32'h1);
        peek(RXD, 32'hA5, "rx_byte");
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h3C;
        cyc();
        bus.rx_valid = 1'b0;
        peek(RXD, 32'hA5, "rx_drop_kept");
        peek(CON, 32'h2A, "rx_overrun_con");
        rd(RXD, 32'hA5, "rx_read");
        peek(CON, 32'h22, "rx_read_clears");
        chk("rx_irq_still", 32'(bus.irq), 32'h1);
        cyc();
        chk("rx_irq_cleared", 32'(bus.irq), 32'h0);

        // Read coinciding with a new byte: old byte returned, new byte kept, no overrun.
        wr(CON, 32'h22);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        cyc();
        bus.rx_valid = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h3C;
        rd(RXD, 32'hA5, "coll_read_old");
        bus.rx_valid = 1'b0;
        peek(RXD, 32'h3C, "coll_new_byte");
        peek(CON, 32'h0A, "coll_con");

        // Random phase from a fresh reset.
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        m_rx_full   = 1'b0;
        m_ov        = 1'b0;
        m_rxie      = 1'b0;
        m_irq       = 1'b0;
        m_txd_known = 1'b0;
        m_rx_byte   = '0;
        m_txd       = '0;
        eng_left    = 0;
        eng_guard   = 0;
        cyc();

        for (int i = 0; i < RAND_CYCLES + DRAIN_CYCLES; i++) begin
            do_ops  = (i < RAND_CYCLES);
            started = 1'b0;
            if (bus.tx_start === 1'b1) begin
                started = 1'b1;
                if (txq.size() == 0) begin
                    chk("rand_unexpected_start", 32'(bus.tx_start), 32'h0);
                end else begin
                    b = txq.pop_front();
                    chk("rand_tx_data", 32'(bus.tx_data), 32'(b));
                end
                if ($urandom_range(0, 9) == 0) begin
                    bus.tx_busy = 1'b0;
                    eng_left    = 0;
                    eng_guard   = 6;
                end else begin
                    bus.tx_busy = 1'b1;
                    eng_left    = int'($urandom_range(1, 25));
                end
            end else if (bus.tx_busy) begin
                eng_left--;
                if (eng_left == 0) begin
                    bus.tx_busy = 1'b0;
                    eng_guard   = 3;
                end
            end else if (eng_guard > 0) begin
                eng_guard--;
            end
            chk("rand_irq", 32'(bus.irq), 32'(m_irq));

            tx_idle = (txq.size() == 0) && !started && !bus.tx_busy && (eng_guard == 0);
            op      = do_ops ? $urandom_range(0, 9) : 0;
            rx_v    = do_ops && ($urandom_range(0, 5) == 0);
            rx_d    = 8'($urandom);
            w       = $urandom;
            bus.we       = 1'b0;
            bus.re       = 1'b0;
            bus.rx_valid = rx_v;
            bus.rx_data  = rx_d;
            rxd_rd       = 1'b0;
            if (op == 3 || op == 4) begin
                bus.re   = 1'b1;
                bus.addr = RXD;
                rxd_rd   = 1'b1;
                #1;
                chk("rand_rxd", bus.rdata, {24'h0, m_rx_byte});
            end else if (op == 5) begin
                bus.re   = 1'b1;
                bus.addr = CON;
                #1;
                exp_con = {26'h0, m_ov, 1'b0, m_rx_full, 1'b0, m_rxie, 1'b0};
                chk("rand_con", bus.rdata & 32'h2B, exp_con);
            end else if (op == 6) begin
                w         = w & ~32'h1;
                bus.we    = 1'b1;
                bus.addr  = CON;
                bus.wdata = w;
            end else if ((op == 7 || op == 8) && tx_idle) begin
                bus.we    = 1'b1;
                bus.addr  = TXD;
                bus.wdata = w;
            end else if (op == 9 && m_txd_known) begin
                bus.re   = 1'b1;
                bus.addr = TXD;
                #1;
                chk("rand_txd", bus.rdata, {24'h0, m_txd});
            end

            new_irq = m_rxie && m_rx_full;
            if (bus.we && bus.addr == CON) begin
                m_rxie = w[1];
                if (w[5]) m_ov = 1'b0;
            end
            if (rx_v) begin
                if (!m_rx_full || rxd_rd) begin
                    m_rx_byte = rx_d;
                    m_rx_full = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (rxd_rd) begin
                m_rx_full = 1'b0;
            end
            if (bus.we && bus.addr == TXD) begin
                txq.push_back(w[7:0]);
                m_txd       = w[7:0];
                m_txd_known = 1'b1;
            end
            m_irq = new_irq;
            cyc();
        end
        bus.we       = 1'b0;
        bus.re       = 1'b0;
        bus.rx_valid = 1'b0;
        chk("rand_tx_drained", 32'(txq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
